// File: rtl/branch_predictor.sv
// Bimodal 2-bit direction predictor for the FD stage, trained from X.
// Define BP_BYPASS_EN to forward a same-cycle update into the lookup.
module branch_predictor #(
  parameter int         INDEX_BITS = 5,
  parameter int         INDEX_LSB  = 2,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_fd,
  input  logic [31:0] inst_fd,
  output logic        jump,
  output logic [1:0]  pred_state,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int         N          = 1 << INDEX_BITS;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] SAT       = 32'hFFFF_FFFF;

  logic [1:0]            cnt_q [N];
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [1:0]            rd_val;
  logic [1:0]            wr_cur;
  logic [1:0]            wr_nxt;
  logic                  is_br;
  logic                  unused_bits;

  assign rd_idx = pc_fd[INDEX_LSB+INDEX_BITS-1:INDEX_LSB];
  assign wr_idx = upd_pc[INDEX_LSB+INDEX_BITS-1:INDEX_LSB];
  assign rd_val = cnt_q[rd_idx];
  assign wr_cur = cnt_q[wr_idx];
  assign is_br  = (inst_fd[6:0] == OPC_BRANCH);

  assign unused_bits = ^{inst_fd, pc_fd, upd_pc};

  always_comb begin
    wr_nxt = wr_cur;
    unique case (1'b1)
      upd_taken && (wr_cur != 2'b11):  wr_nxt = wr_cur + 2'd1;
      !upd_taken && (wr_cur != 2'b00): wr_nxt = wr_cur - 2'd1;
      default: ;
    endcase
  end

`ifdef BP_BYPASS_EN
  // forward the counter being written this edge to the FD lookup
  assign pred_state = (rst && upd_valid && (wr_idx == rd_idx)) ? wr_nxt : rd_val;
`else
  assign pred_state = rd_val;
`endif

  assign jump = rst & is_br & pred_state[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= INIT_STATE;
      end
    end else if (upd_valid) begin
      cnt_q[wr_idx] <= wr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (stat_branches != SAT) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (upd_mispredict && (stat_mispredicts != SAT)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan plus random traffic
// against a counter-array model of the predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_fd;
  logic [31:0] inst_fd;
  logic        jump;
  logic [1:0]  pred_state;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk),
    .rst(rst),
    .pc_fd(pc_fd),
    .inst_fd(inst_fd),
    .jump(jump),
    .pred_state(pred_state),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        j;
    logic [1:0]  ps;
    logic [31:0] sb;
    logic [31:0] sm;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // model: plain integers, 32 entries selected by word address mod 32
  int     mcnt [32];
  longint msb;
  longint msm;

  localparam logic [31:0] BR   = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ALU  = 32'h0000_0033;

  function automatic int step(input int c, input logic t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic cyc(input logic r, input logic [31:0] pc,
                     input logic [31:0] ins, input logic uv,
                     input logic [31:0] upc, input logic ut,
                     input logic um, input bit chk, input string tag);
    int   li;
    int   ui;
    int   ps;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pc_fd = pc; inst_fd = ins;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_mispredict = um;
    li = int'((pc / 4) % 32);
    ui = int'((upc / 4) % 32);
    ps = mcnt[li];
`ifdef BP_BYPASS_EN
    if (r && uv && (li == ui)) ps = step(mcnt[ui], ut);
`endif
    e.j   = r && (ins[6:0] == 7'b1100011) && (ps >= 2);
    e.ps  = 2'(ps);
    e.sb  = 32'(msb);
    e.sm  = 32'(msm);
    e.tag = tag;
    if (chk) exp_q.push_back(e);
    if (!r) begin
      foreach (mcnt[i]) mcnt[i] = 1;
      msb = 0;
      msm = 0;
    end else if (uv) begin
      mcnt[ui] = step(mcnt[ui], ut);
      if (msb < 64'hFFFF_FFFF) msb++;
      if (um && msm < 64'hFFFF_FFFF) msm++;
    end
  endtask

  // monitor: combinational outputs settle mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (jump !== e.j || pred_state !== e.ps ||
          stat_branches !== e.sb || stat_mispredicts !== e.sm) begin
        bad++;
        $display("FAIL %s: got jump=%b ps=%b sb=%0d sm=%0d want jump=%b ps=%b sb=%0d sm=%0d",
                 e.tag, jump, pred_state, stat_branches, stat_mispredicts,
                 e.j, e.ps, e.sb, e.sm);
      end
    end
  end

  logic [31:0] pcs [8];

  initial begin
    rst = 1'b0; pc_fd = '0; inst_fd = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    foreach (mcnt[i]) mcnt[i] = 1;
    msb = 0; msm = 0;
    pcs = '{32'h100, 32'h104, 32'h080, 32'h200, 32'h17C, 32'h0FC, 32'h108, 32'h300};

    cyc(0, 32'h100, BR, 0, 0, 0, 0, 0, "reset");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "after_reset");

    cyc(1, 32'h104, BR, 1, 32'h100, 1, 0, 1, "tk1");
    cyc(1, 32'h104, BR, 1, 32'h100, 1, 0, 1, "tk2");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "strong_t");
    cyc(1, 32'h104, BR, 1, 32'h100, 1, 1, 1, "tk3");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "sat_hi");

    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h104, BR, 1, 32'h100, 0, 1, 1, "nt");
      cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "nt_look");
    end
    cyc(1, 32'h104, BR, 1, 32'h100, 0, 0, 1, "nt_sat");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "sat_lo");

    cyc(1, 32'h104, BR, 1, 32'h100, 1, 0, 1, "up1");
    cyc(1, 32'h104, BR, 1, 32'h100, 1, 0, 1, "up2");
    cyc(1, 32'h100, JAL, 0, 0, 0, 0, 1, "jal");
    cyc(1, 32'h100, JALR, 0, 0, 0, 0, 1, "jalr");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "weak_t");

    cyc(0, 32'h100, BR, 0, 0, 0, 0, 1, "reset_mid");
    cyc(1, 32'h104, BR, 1, 32'h080, 1, 0, 1, "alias1");
    cyc(1, 32'h104, BR, 1, 32'h080, 1, 0, 1, "alias2");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "alias_hit");
    cyc(1, 32'h104, BR, 0, 0, 0, 0, 1, "alias_miss");

    cyc(0, 32'h100, BR, 1, 32'h100, 1, 1, 1, "reset_drops_upd");
    cyc(1, 32'h100, BR, 1, 32'h100, 1, 0, 1, "hazard");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "hazard_next");

    cyc(0, 32'h100, BR, 0, 0, 0, 0, 1, "reset2");
    cyc(1, 32'h104, BR, 1, 32'h100, 1, 1, 1, "s1");
    cyc(1, 32'h104, BR, 1, 32'h100, 0, 0, 1, "s2");
    cyc(1, 32'h104, BR, 1, 32'h108, 1, 1, 1, "s3");
    cyc(1, 32'h104, BR, 0, 32'h108, 1, 1, 1, "s_idle");
    cyc(1, 32'h104, BR, 1, 32'h108, 1, 0, 1, "s4");
    cyc(1, 32'h104, BR, 1, 32'h100, 1, 0, 1, "s5");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "stats5");
    cyc(0, 32'h100, BR, 0, 0, 0, 0, 1, "stats_rst");
    cyc(1, 32'h100, BR, 0, 0, 0, 0, 1, "stats_clr");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      case ($urandom_range(0, 4))
        0, 1: ins = BR | ($urandom & 32'hFFFF_FF80);
        2: ins = JAL;
        3: ins = JALR;
        default: ins = $urandom;
      endcase
      cyc(($urandom_range(0, 99) != 0), pcs[$urandom_range(0, 7)], ins,
          1'($urandom_range(0, 1)), pcs[$urandom_range(0, 7)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, "rand");
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
